// File: rtl/paicore_send_sched.sv
// paicore_send_sched: transfer-level controller for the PAICORE host-to-core
// send datapath.
//
// Accepts a host transfer command, rejects malformed ones, flushes the send
// datapath through its active-low reset, then opens the channel output enables
// and counts accepted words until the programmed length is reached. After that
// it waits for the XC channels to drain and reports completion. Stalls and host
// aborts take a flush path back to idle.
//
// Ports
//   s_axis_aclk, s_axis_aresetn      clock, async active-low reset
//   cfg_start / cfg_abort            one-cycle command pulses from the register file
//   cfg_send_len, cfg_ch_mask,
//   cfg_single, cfg_timeout          transfer command, sampled only with an accepted start
//   write_hsked                      one pulse per word accepted by the datapath
//   tx_done                          level: all XC channels idle and empty
//   dp_aresetn, oen, single_channel,
//   single_channel_mask, send_len    datapath configuration
//   busy, done, err_timeout, err_cfg,
//   words_sent                       status back to the register file
module paicore_send_sched #(
  parameter int Channel      = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_aresetn,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [31:0]        cfg_send_len,
  input  logic [Channel-1:0] cfg_ch_mask,
  input  logic               cfg_single,
  input  logic [31:0]        cfg_timeout,
  input  logic               write_hsked,
  input  logic               tx_done,
  output logic               dp_aresetn,
  output logic [Channel-1:0] oen,
  output logic               single_channel,
  output logic [Channel-1:0] single_channel_mask,
  output logic [31:0]        send_len,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               err_cfg,
  output logic [31:0]        words_sent
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, FLUSH, ARM, RUN, DRAIN, DONE, ABORT} state_t;

  state_t      state;
  logic [FW-1:0] fcnt;     // cycles spent in FLUSH / ABORT
  logic [31:0] stall;      // consecutive cycles without a handshake
  logic [31:0] tmo;        // stall limit latched with the command
  logic        td_seen;    // tx_done was high in the previous DRAIN cycle

  logic        cfg_bad, flush_last, stall_hit;
  logic [31:0] ws_inc, ws_next;

  assign cfg_bad    = (cfg_send_len == 32'd0) || (cfg_ch_mask == '0) ||
                      (cfg_single && !$onehot(cfg_ch_mask));
  assign flush_last = (fcnt == FW'(FLUSH_CYCLES - 1));
  // Saturate so a runaway overrun never wraps back to a small count.
  assign ws_inc     = (&words_sent) ? words_sent : words_sent + 32'd1;
  assign ws_next    = write_hsked ? ws_inc : words_sent;
  // Fires on the idle cycle that brings the stall run up to the limit.
  assign stall_hit  = (tmo != 32'd0) && !write_hsked && (stall + 32'd1 == tmo);

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state               <= IDLE;
      fcnt                <= '0;
      stall               <= '0;
      tmo                 <= '0;
      td_seen             <= 1'b0;
      dp_aresetn          <= 1'b0;
      oen                 <= '0;
      single_channel      <= 1'b0;
      single_channel_mask <= '0;
      send_len            <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      err_timeout         <= 1'b0;
      err_cfg             <= 1'b0;
      words_sent          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cfg_start) begin
          err_timeout <= 1'b0;
          if (cfg_bad) begin
            err_cfg <= 1'b1;
          end else begin
            err_cfg             <= 1'b0;
            send_len            <= cfg_send_len;
            single_channel      <= cfg_single;
            single_channel_mask <= cfg_ch_mask;
            tmo                 <= cfg_timeout;
            words_sent          <= '0;
            fcnt                <= '0;
            busy                <= 1'b1;
            state               <= FLUSH;
          end
        end
        FLUSH: begin
          if (cfg_abort) begin
            state <= ABORT;
            fcnt  <= '0;
          end else if (flush_last) begin
            state      <= ARM;
            dp_aresetn <= 1'b1;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
        ARM: begin
          if (cfg_abort) begin
            state      <= ABORT;
            fcnt       <= '0;
            dp_aresetn <= 1'b0;
          end else begin
            state <= RUN;
            // In single mode the latched mask is already one-hot.
            oen   <= single_channel_mask;
            stall <= '0;
          end
        end
        RUN, DRAIN: begin
          // A handshake in the abort/timeout/completion cycle still counts.
          words_sent <= ws_next;
          if (cfg_abort || stall_hit) begin
            state      <= ABORT;
            fcnt       <= '0;
            dp_aresetn <= 1'b0;
            oen        <= '0;
            if (stall_hit) err_timeout <= 1'b1;
          end else if (state == RUN && ws_next == send_len) begin
            state   <= DRAIN;
            stall   <= '0;
            td_seen <= 1'b0;
          end else begin
            stall <= write_hsked ? 32'd0 : stall + 32'd1;
            if (state == DRAIN) begin
              if (!tx_done) begin
                td_seen <= 1'b0;
              end else if (!td_seen) begin
                td_seen <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
                oen   <= '0;
              end
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          dp_aresetn <= 1'b0;
        end
        ABORT: begin
          if (flush_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          dp_aresetn <= 1'b0;
          oen        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paicore_send_sched.sv
// Bench for paicore_send_sched: directed transfer scenarios. Each scenario is
// turned into a per-cycle expected waveform from the transfer rules, and a
// single negedge process compares every output against it.
module tb_paicore_send_sched;
  localparam int CH = 4;
  localparam int F  = 4;
  localparam int N  = 40;   // cycles per scenario
  localparam int R0 = F + 2; // first RUN cycle relative to the start cycle

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_start, cfg_abort, cfg_single, write_hsked, tx_done;
  logic [31:0] cfg_send_len, cfg_timeout;
  logic [CH-1:0] cfg_ch_mask;
  logic dp_aresetn, single_channel, busy, done, err_timeout, err_cfg;
  logic [CH-1:0] oen, single_channel_mask;
  logic [31:0] send_len, words_sent;

  always #5 clk = ~clk;

  paicore_send_sched #(.Channel(CH), .FLUSH_CYCLES(F)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_send_len(cfg_send_len),
    .cfg_ch_mask(cfg_ch_mask), .cfg_single(cfg_single), .cfg_timeout(cfg_timeout),
    .write_hsked(write_hsked), .tx_done(tx_done),
    .dp_aresetn(dp_aresetn), .oen(oen), .single_channel(single_channel),
    .single_channel_mask(single_channel_mask), .send_len(send_len), .busy(busy),
    .done(done), .err_timeout(err_timeout), .err_cfg(err_cfg), .words_sent(words_sent)
  );

  int total = 0, bad = 0;
  int rel = 0;
  bit chk_en = 0;

  logic          e_busy[N], e_dp[N], e_done[N], e_errt[N], e_errc[N], e_single[N];
  logic [CH-1:0] e_oen[N], e_mask[N];
  logic [31:0]   e_ws[N], e_len[N];

  // status carried between scenarios
  logic [31:0]   p_ws = 0, p_len = 0;
  logic [CH-1:0] p_mask = 0;
  logic          p_single = 0, p_errt = 0, p_errc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s rel=%0d got=%0h want=%0h", nm, rel, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("busy", busy, e_busy[rel]);
    chk("dp_aresetn", dp_aresetn, e_dp[rel]);
    chk("oen", oen, e_oen[rel]);
    chk("done", done, e_done[rel]);
    chk("err_timeout", err_timeout, e_errt[rel]);
    chk("err_cfg", err_cfg, e_errc[rel]);
    chk("words_sent", words_sent, e_ws[rel]);
    chk("send_len", send_len, e_len[rel]);
    chk("sc_mask", single_channel_mask, e_mask[rel]);
    chk("single", single_channel, e_single[rel]);
  end

  // Expected waveform of one transfer whose start pulse is in cycle 0.
  // d_out = cycle of the done pulse, ab_out = last cycle before ABORT (-1 if none).
  task automatic model(input int len, input logic [CH-1:0] mask, input logic single,
                       input int tmo, input logic [63:0] hv, input int td, input int ab,
                       output int d_out, output int ab_out);
    int cnt, idle, stop, d, abk, lastb, lastdp, acc;
    bit drain, seen, tfire, h, t, fire, illegal;
    cnt = 0; idle = 0; stop = -1; d = -1; abk = -1;
    drain = 0; seen = 0; tfire = 0;
    illegal = (len == 0) || (mask == 0) || (single && $countones(mask) != 1);
    for (int k = 0; k < N; k++) begin
      e_busy[k] = 0; e_dp[k] = 0; e_oen[k] = 0; e_done[k] = 0;
      e_errt[k] = p_errt; e_errc[k] = p_errc; e_ws[k] = p_ws;
      e_len[k] = p_len; e_mask[k] = p_mask; e_single[k] = p_single;
    end
    if (illegal) begin
      for (int k = 1; k < N; k++) begin e_errc[k] = 1; e_errt[k] = 0; end
    end else begin
      if (ab >= 1 && ab <= F + 1) abk = ab;
      else begin
        for (int k = R0; k < N; k++) begin
          h = hv[k]; t = (td >= 0) && (k >= td);
          fire = (tmo != 0) && !h && (idle + 1 == tmo);
          if (fire || k == ab) begin abk = k; tfire = fire; stop = k; break; end
          idle = h ? 0 : idle + 1;
          cnt += int'(h);
          if (!drain) begin
            if (cnt == len) begin drain = 1; idle = 0; end
          end else if (t) begin
            if (seen) begin d = k + 1; stop = k; break; end
            seen = 1;
          end else seen = 0;
        end
      end
      lastb  = (d >= 0) ? d : abk + F;
      lastdp = (d >= 0) ? d : abk;
      acc = 0;
      for (int k = 1; k < N; k++) begin
        if (k - 1 >= R0 && k - 1 <= stop) acc += int'(hv[k-1]);
        e_errc[k] = 0; e_errt[k] = tfire && (k > abk);
        e_len[k] = len; e_mask[k] = mask; e_single[k] = single;
        e_busy[k] = (k <= lastb);
        e_dp[k]   = (k >= F + 1) && (k <= lastdp);
        e_oen[k]  = (k >= R0 && k <= stop) ? mask : '0;
        e_done[k] = (k == d);
        e_ws[k]   = acc;
      end
    end
    p_ws = e_ws[N-1]; p_len = e_len[N-1]; p_mask = e_mask[N-1];
    p_single = e_single[N-1]; p_errt = e_errt[N-1]; p_errc = e_errc[N-1];
    d_out = d; ab_out = abk;
  endtask

  task automatic idle_inputs();
    cfg_start = 0; cfg_abort = 0; write_hsked = 0; tx_done = 0;
    cfg_send_len = 0; cfg_ch_mask = 0; cfg_single = 0; cfg_timeout = 0;
  endtask

  // Drives one scenario; config inputs are scrambled after the start cycle.
  task automatic run_scn(input int len, input logic [CH-1:0] mask, input logic single,
                         input int tmo, input logic [63:0] hv, input int td, input int ab,
                         input int stray, output int d_out, output int ab_out);
    model(len, mask, single, tmo, hv, td, ab, d_out, ab_out);
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      rel = k; chk_en = 1;
      if (k == 0) begin
        cfg_send_len = len; cfg_ch_mask = mask; cfg_single = single; cfg_timeout = tmo;
      end else begin
        cfg_send_len = len + 15; cfg_ch_mask = ~mask; cfg_single = ~single; cfg_timeout = 3;
      end
      cfg_start   = (k == 0) || (k == stray);
      cfg_abort   = (k == ab);
      write_hsked = hv[k];
      tx_done     = (td >= 0) && (k >= td);
    end
    @(posedge clk); #1;
    chk_en = 0;
    idle_inputs();
  endtask

  int d, a;

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_dp", dp_aresetn, 0);
    chk("rst_ws", words_sent, 0);
    chk("rst_errc", err_cfg, 0);
    @(negedge clk); rst_n = 1;

    // fork, len 8, stray handshake in FLUSH ignored
    run_scn(8, 4'b1111, 0, 0, 64'h3FC8, 10, -1, -1, d, a);
    chk("s1_done_cycle", d, 16);
    chk("s1_ws", words_sent, 8);
    // single channel, gapped handshakes
    run_scn(3, 4'b0100, 1, 0, 64'hA80, 15, -1, -1, d, a);
    chk("s2_done_cycle", d, 17);
    // timeout while draining
    run_scn(2, 4'b0011, 0, 5, 64'hC0, -1, -1, -1, d, a);
    chk("s9_abort_cycle", a, 12);
    // illegal commands
    run_scn(0, 4'b1111, 0, 0, 64'h0, -1, -1, -1, d, a);
    chk("s3_errc", err_cfg, 1);
    chk("s3_errt_cleared", err_timeout, 0);
    run_scn(4, 4'b0110, 1, 0, 64'h0, -1, -1, -1, d, a);
    run_scn(4, 4'b0000, 0, 0, 64'h0, -1, -1, -1, d, a);
    // timeout in RUN; also clears err_cfg
    run_scn(5, 4'b1111, 0, 10, 64'hC0, -1, -1, -1, d, a);
    chk("s5_abort_cycle", a, 17);
    chk("s5_ws", words_sent, 2);
    chk("s5_errt", err_timeout, 1);
    // abort together with the final handshake
    run_scn(4, 4'b1010, 0, 0, 64'h3C0, 12, 9, -1, d, a);
    chk("s6_no_done", d, -1);
    // stray start mid-RUN ignored; late handshake in IDLE ignored
    run_scn(5, 4'b0111, 0, 0, 64'h1007C0, 12, -1, 8, d, a);
    chk("s7_done_cycle", d, 14);
    chk("s7_len", send_len, 5);
    // abort during FLUSH
    run_scn(6, 4'b1111, 0, 0, 64'h0, -1, 2, -1, d, a);

    // async reset in the middle of RUN
    @(posedge clk); #1;
    cfg_start = 1; cfg_send_len = 8; cfg_ch_mask = 4'hF;
    @(posedge clk); #1;
    idle_inputs();
    repeat (7) @(posedge clk);
    #3;
    chk("pre_rst_oen", oen, 4'hF);
    rst_n = 0; #1;
    chk("mid_rst_oen", oen, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_len", send_len, 0);
    chk("mid_rst_mask", single_channel_mask, 0);
    chk("mid_rst_dp", dp_aresetn, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_dp", dp_aresetn, 0);
    end
    p_ws = 0; p_len = 0; p_mask = 0; p_single = 0; p_errt = 0; p_errc = 0;
    run_scn(8, 4'b1111, 0, 0, 64'h3FC0, 10, -1, -1, d, a);
    chk("s11_done_cycle", d, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
